// File: rtl/system_qsys_pio_pkg.sv
// Shared register map and STATUS layout for the Avalon-MM output PIO.
package system_qsys_pio_pkg;

   typedef enum logic [2:0] {
      ADDR_DATA   = 3'd0,
      ADDR_MODE   = 3'd1,
      ADDR_PERIOD = 3'd2,
      ADDR_STATUS = 3'd3,
      ADDR_OUTSET = 3'd4,
      ADDR_OUTCLR = 3'd5,
      ADDR_OUTTGL = 3'd6,
      ADDR_RSVD   = 3'd7
   } reg_addr_e;

   localparam int STATUS_PHASE_BIT   = 0;
   localparam int STATUS_RUNNING_BIT = 1;

   function automatic logic [31:0] status_word(input logic phase, input logic running);
      logic [31:0] w;
      w = '0;
      w[STATUS_PHASE_BIT]   = phase;
      w[STATUS_RUNNING_BIT] = running;
      return w;
   endfunction

endpackage

// File: rtl/system_qsys_pio_blink_timer.sv
// Programmable half-period timer producing the blink phase; load_val doubles as the
// steady reload value, so a PERIOD write is simply a load with the new value.
module system_qsys_pio_blink_timer #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             phase,
   output logic             running
);

   logic [CNT_W-1:0] counter;

   // NOTE: all state here is sequential, so every assignment is non-blocking to keep
   // reads of counter/phase seeing the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         phase   <= 1'b0;
         running <= 1'b0;
      end else if (load) begin
         counter <= load_val;
         phase   <= 1'b0;
         running <= |load_val;
      end else if (load_val == '0) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (counter == '0) begin
         phase   <= ~phase;
         counter <= load_val;
      end else begin
         counter <= counter - CNT_W'(1);
      end
   end

endmodule

// File: rtl/system_qsys_pio_out.sv
// Parametrised Avalon-MM output PIO with set/clear/toggle strobes and per-bit blink.
module system_qsys_pio_out
   import system_qsys_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q, mode_q, data_d;
   logic [CNT_W-1:0] period_q, timer_val;
   logic [WIDTH-1:0] wd;
   logic [31:0]      rd_word;
   logic             wr_en, rd_en, period_wr;
   logic             phase, running;
   reg_addr_e        addr;
   logic             unused_writedata;

   assign addr      = reg_addr_e'(address);
   assign wr_en     = chipselect & ~write_n;
   assign rd_en     = chipselect & write_n;
   assign period_wr = wr_en && (addr == ADDR_PERIOD);
   assign wd        = writedata[WIDTH-1:0];
   assign timer_val = period_wr ? writedata[CNT_W-1:0] : period_q;

   // Bits above WIDTH/CNT_W are architecturally ignored.
   assign unused_writedata = ^writedata;

   system_qsys_pio_blink_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (period_wr),
      .load_val (timer_val),
      .phase    (phase),
      .running  (running)
   );

   // NOTE: every path through this block assigns data_d first, so no latch is inferred.
   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (addr)
            ADDR_DATA:   data_d = wd;
            ADDR_OUTSET: data_d = data_q | wd;
            ADDR_OUTCLR: data_d = data_q & ~wd;
            ADDR_OUTTGL: data_d = data_q ^ wd;
            default:     data_d = data_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= RESET_VALUE;
         mode_q   <= '0;
         period_q <= '0;
      end else begin
         data_q <= data_d;
         if (wr_en && addr == ADDR_MODE) mode_q   <= wd;
         if (period_wr)                  period_q <= writedata[CNT_W-1:0];
      end
   end

   always_comb begin
      rd_word = '0;
      case (addr)
         ADDR_DATA:   rd_word[WIDTH-1:0] = data_q;
         ADDR_MODE:   rd_word[WIDTH-1:0] = mode_q;
         ADDR_PERIOD: rd_word[CNT_W-1:0] = period_q;
         ADDR_STATUS: rd_word            = status_word(phase, running);
         default:     rd_word            = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)      readdata <= '0;
      else if (rd_en) readdata <= rd_word;
   end

   assign out_port = data_q ^ (mode_q & {WIDTH{phase}});

endmodule

// File: tb/tb_system_qsys_pio_out.sv
// Self-checking bench: directed steps plus random bus traffic against an arithmetic model.
module tb_system_qsys_pio_out;

   localparam int            W  = 4;
   localparam int            CW = 24;
   localparam logic [W-1:0]  RV = 4'b1010;
   localparam logic [31:0]   RV_WIDE = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;
   logic [31:0]   readdata_wide;
   logic [31:0]   out_wide;

   always #5 clk = ~clk;

   system_qsys_pio_out #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   system_qsys_pio_out #(.WIDTH(32), .RESET_VALUE(RV_WIDE), .CNT_W(1)) dut_wide (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata_wide),
      .out_port   (out_wide)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Model: registers plus the edge index of the last PERIOD write; phase follows from
   // elapsed edges divided by the half-period P+1.
   longint       ecnt = 0;
   logic [W-1:0] m_data, m_mode;
   longint       m_period;
   longint       m_pw;

   function automatic logic m_phase();
      if (m_period == 0) return 1'b0;
      return (((ecnt - m_pw) / (m_period + 1)) % 2) == 1;
   endfunction

   function automatic logic [31:0] m_out();
      return 32'(m_data ^ (m_phase() ? m_mode : '0));
   endfunction

   function automatic logic [31:0] m_reg(input int a);
      case (a)
         0:       return 32'(m_data);
         1:       return 32'(m_mode);
         2:       return 32'(m_period);
         3:       return {30'd0, (m_period != 0), m_phase()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_data   = RV;
      m_mode   = '0;
      m_period = 0;
      m_pw     = ecnt;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      @(posedge clk); #1;
      ecnt++;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      address    = 3'(a);
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk); #1;
      ecnt++;
      case (a)
         0: m_data = d[W-1:0];
         1: m_mode = d[W-1:0];
         2: begin m_period = longint'(d[CW-1:0]); m_pw = ecnt; end
         4: m_data = m_data | d[W-1:0];
         5: m_data = m_data & ~d[W-1:0];
         6: m_data = m_data ^ d[W-1:0];
         default: ;
      endcase
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input int a, input string tag);
      logic [31:0] exp;
      exp        = m_reg(a);
      address    = 3'(a);
      chipselect = 1'b1;
      write_n    = 1'b1;
      @(posedge clk); #1;
      ecnt++;
      chipselect = 1'b0;
      check(tag, readdata, exp);
   endtask

   initial begin
      int guard;
      logic [31:0] d;
      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      @(posedge clk); #1; ecnt++;
      @(posedge clk); #1; ecnt++;
      model_reset();
      reset = 1'b0;

      check("rst_out", 32'(out_port), 32'h0000_000A);
      check("rst_out_wide", out_wide, RV_WIDE);
      rd(0, "rst_rd_data");
      check("rst_rd_data_const", readdata, 32'h0000_000A);
      check("rst_rd_wide", readdata_wide, RV_WIDE);
      rd(1, "rst_rd_mode");
      rd(2, "rst_rd_period");
      rd(3, "rst_rd_status");

      wr(0, 32'h5); check("wr_data", 32'(out_port), 32'h5);
      check("wide_data", out_wide, 32'h5);
      wr(4, 32'h8); check("outset", 32'(out_port), 32'hD);
      wr(5, 32'h1); check("outclr", 32'(out_port), 32'hC);
      wr(6, 32'h3); check("outtgl", 32'(out_port), 32'hF);
      rd(4, "rd_addr4");
      check("rd_addr4_const", readdata, 32'h0);

      // Blink on bit 0 with P=3: toggles every 4 edges starting 4 edges after the write.
      wr(1, 32'h1);
      wr(0, 32'h0);
      wr(2, 32'h3);
      for (int i = 1; i <= 12; i++) begin
         tick();
         check($sformatf("blink_p3_%0d", i), 32'(out_port), 32'(((i / 4) % 2)));
      end
      rd(3, "status_p3");
      rd(3, "status_p3_b");

      guard = 0;
      while (!m_phase() && guard < 8) begin tick(); guard++; end
      check("phase_hi_reached", 32'(out_port), 32'h1);
      wr(2, 32'h0);
      check("period0_static", 32'(out_port), 32'h0);
      rd(3, "status_stopped");
      wr(2, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("blink_p1_%0d", i), 32'(out_port), m_out());
      end

      // OUTTGL lands on the same edge as a phase toggle: bit 0 must not change.
      wr(1, 32'h1);
      wr(0, 32'h0);
      wr(2, 32'h3);
      tick(); tick(); tick();
      check("sim_before", 32'(out_port), 32'h0);
      wr(6, 32'h1);
      check("sim_after", 32'(out_port), 32'h0);
      check("sim_model", 32'(out_port), m_out());
      rd(0, "sim_rd_data");

      for (int i = 0; i < 300; i++) begin
         int r, a;
         r = int'($urandom_range(0, 9));
         a = int'($urandom_range(0, 7));
         if (r < 6) begin
            d = $urandom;
            if (a == 2) d = (d & 32'hFF00_0000) | $urandom_range(0, 5);
            wr(a, d);
         end else if (r < 8) begin
            rd(a, $sformatf("rnd_rd_%0d", i));
         end else begin
            tick();
         end
         check($sformatf("rnd_out_%0d", i), 32'(out_port), m_out());
      end

      // Reset dominating a DATA write while blinking.
      wr(0, 32'h6);
      wr(1, 32'hF);
      wr(2, 32'h2);
      tick(); tick(); tick();
      rd(0, "pre_rst_rd");
      reset = 1'b1; address = 3'd0; writedata = 32'hF; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1; ecnt++;
      model_reset();
      chipselect = 1'b0; write_n = 1'b1;
      check("rst_mid_out", 32'(out_port), 32'h0000_000A);
      check("rst_mid_rdata", readdata, 32'h0);
      reset = 1'b0;
      tick(); tick(); tick();
      check("rst_mid_static", 32'(out_port), 32'h0000_000A);
      rd(2, "rst_mid_period");
      rd(3, "rst_mid_status");
      rd(1, "rst_mid_mode");
      rd(0, "rst_mid_data");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
